// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//   Fully synchronous up/down counter over the range 0..MAX_COUNT with
//   parallel load, wrap or saturate at the limits, a terminal-count
//   indication and boundary-event flags.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   MAX_COUNT  top of the count range, 0 < MAX_COUNT <= 2**WIDTH-1
//   SATURATE   0 = wrap at the limits, 1 = hold at the limit
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   en         count enable
//   up_dn      direction, 1 = up, 0 = down
//   load       parallel load strobe (beats en)
//   load_val   value to load, clamped to MAX_COUNT
//   clr_flags  clears ovf/unf on the next edge
//   count      registered count value
//   tc         terminal count (combinational, not masked by load)
//   roll       one-cycle pulse aligned with the count produced by an event
//   ovf, unf   sticky overflow / underflow flags
module sync_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             roll,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic at_max, at_zero;
  logic ovf_evt, unf_evt;

  assign at_max  = (count_q == MAX_V);
  assign at_zero = (count_q == '0);

  // A load takes priority over counting, so a boundary hit while loading
  // is reported on tc but is not an event.
  assign ovf_evt = en & ~load &  up_dn & at_max;
  assign unf_evt = en & ~load & ~up_dn & at_zero;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          count_d = (SATURATE != 0) ? MAX_V : '0;
        end else begin
          count_d = count_q + ONE_V;
        end
      end else begin
        if (at_zero) begin
          count_d = (SATURATE != 0) ? '0 : MAX_V;
        end else begin
          count_d = count_q - ONE_V;
        end
      end
    end
  end

  // Setting a flag beats clearing it, so an event coinciding with
  // clr_flags leaves only that event's flag set.
  always_comb begin
    roll_d = ovf_evt | unf_evt;
    ovf_d  = ovf_evt | (ovf_q & ~clr_flags);
    unf_d  = unf_evt | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tc    = en & ((up_dn & at_max) | (~up_dn & at_zero));
  assign count = count_q;
  assign roll  = roll_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
Parametrised, fully synchronous up/down counter. Successor to the ripple counters in the sequential counter library. All bits update on one clock edge; the block adds a programmable modulus, parallel load, selectable wrap or saturate at the limits, and boundary-event flags. Intended as the general-purpose counter for timers, dividers and address generators.

Parameters:
WIDTH, 4, counter width in bits (>=1).
MAX_COUNT, 9, top of the count range; the range is 0..MAX_COUNT. Must satisfy 0 < MAX_COUNT <= 2**WIDTH-1.
SATURATE, 0, limit behaviour: 0 = wrap at the limits, 1 = hold at the limit.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  count enable.
up_dn  input  1  count direction: 1 = up, 0 = down.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value to load.
clr_flags  input  1  clears the sticky flags.
count  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational.
roll  output  1  one-cycle registered boundary-event pulse.
ovf  output  1  sticky overflow flag.
unf  output  1  sticky underflow flag.

Behaviour:
- Reset is synchronous and active-high. When rst=1 at a rising clk edge: count=0, roll=0, ovf=0, unf=0. rst has priority over every other input.
- Input priority per edge is rst > load > en. With en=0 and load=0, count holds.
- Load:
  - If load_val <= MAX_COUNT, count <= load_val on the next edge.
  - If load_val > MAX_COUNT, count <= MAX_COUNT (clamped).
  - A load never sets roll, ovf or unf.
- Count up (en=1, up_dn=1):
  - If count < MAX_COUNT: count <= count+1.
  - If count == MAX_COUNT: this is an overflow event. Next count is 0 when SATURATE=0, or MAX_COUNT when SATURATE=1.
- Count down (en=1, up_dn=0):
  - If count > 0: count <= count-1.
  - If count == 0: this is an underflow event. Next count is MAX_COUNT when SATURATE=0, or 0 when SATURATE=1.
- Arithmetic: all arithmetic is modulo the 0..MAX_COUNT range. count is never outside 0..MAX_COUNT, including when MAX_COUNT < 2**WIDTH-1.
- tc = en & ((up_dn & count==MAX_COUNT) | (~up_dn & count==0)).
  - tc is high exactly in the cycle whose edge produces an overflow or underflow event.
  - tc is not masked by load. When load=1, tc may be high but no event occurs.
- roll:
  - roll <= 1 on an edge where an overflow or underflow event occurs (en=1, load=0, rst=0, tc=1); otherwise roll <= 0.
  - roll is a single-cycle pulse, aligned with the updated count.
  - Events on consecutive edges (e.g. saturate hold with en held) give roll high on each of those cycles.
- ovf and unf:
  - ovf is set on an overflow event; unf is set on an underflow event. Each stays set until rst or clr_flags.
  - clr_flags=1 clears both flags on the next edge.
  - If clr_flags coincides with an event, the set for that event wins and the other flag clears.
- Direction change: up_dn may change on any cycle. The new direction takes effect on the same edge, with no dead cycle.
- Reset mid-count: count returns to 0 on the reset edge. Counting resumes from 0 on the first edge after rst deasserts.

Test Plan:
- Reset and up-wrap (WIDTH=4, MAX=9, SAT=0): rst 2 cycles, then en=1 and up_dn=1 for 12 edges -> count 0,1..9,0,1,2; tc high only at count=9; roll high one cycle with count=0; ovf=1, unf=0.
- Down-wrap: load 1, then en=1, up_dn=0 for 3 edges -> count 1,0,9,8; tc high at count=0; roll pulses with count=9; unf=1.
- Saturate (SAT=1): from 8 count up 4 edges -> 9,9,9,9; roll high on 3 consecutive cycles; ovf=1. From 0 counting down -> holds 0, unf=1.
- Load priority and clamp: load=1, en=1, load_val=5 -> count=5 and no roll. load_val=14 -> count=9. Then load=0, en=1, up -> count=0 with roll=1.
- Flags: clr_flags with no event -> ovf=unf=0. clr_flags on the same edge as an overflow -> ovf=1, unf=0. rst mid-count at 6 -> count=0 and all flags 0 on that edge.
- Direction toggle and enable: alternate up_dn each edge starting from 4 -> 5,4,5,4. en=0 -> count holds, tc=0, roll=0.
